// File: rtl/bill_checkout_ctrl.sv
// Checkout controller: accumulates priced item lines into a bill, applies a threshold discount, and holds the result until acknowledged.
// Optional macro BILL_LINE_COUNT_EN adds the line_cnt output. "final" is a reserved word, so the net amount port is named final_amt.
module bill_checkout_ctrl #(
  parameter logic [7:0]  PRICE0      = 8'd10,
  parameter logic [7:0]  PRICE1      = 8'd20,
  parameter logic [7:0]  PRICE2      = 8'd30,
  parameter logic [7:0]  PRICE3      = 8'd40,
  parameter logic [7:0]  PRICE4      = 8'd50,
  parameter logic [12:0] DISC_THRESH = 13'd500,
  parameter int          DISC_SHIFT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        item_valid,
  output logic        item_ready,
  input  logic [2:0]  item_id,
  input  logic [3:0]  qty,
  input  logic        close,
  output logic        bill_valid,
  input  logic        bill_ack,
  output logic [12:0] total,
  output logic        ed,
  output logic [12:0] discount,
  output logic [12:0] final_amt,
  output logic        err
`ifdef BILL_LINE_COUNT_EN
  ,output logic [4:0] line_cnt
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] CALC    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state;
  logic [7:0]  unit_price;
  logic        item_bad;
  logic [11:0] prod;
  logic [13:0] sum_wide;
  logic [12:0] sum_sat;
  logic        accept;
  logic        disc_hit;
  logic [12:0] disc_calc;

  assign item_ready = (state == COLLECT);
  assign bill_valid = (state == DONE);
  assign accept     = item_valid && item_ready;

  always_comb begin
    unit_price = 8'd0;
    item_bad   = 1'b0;
    case (item_id)
      3'd0:    unit_price = PRICE0;
      3'd1:    unit_price = PRICE1;
      3'd2:    unit_price = PRICE2;
      3'd3:    unit_price = PRICE3;
      3'd4:    unit_price = PRICE4;
      default: item_bad   = 1'b1;
    endcase
  end

  // 15 * 255 fits in 12 bits, so the product never overflows; only the running sum saturates.
  assign prod      = {8'd0, qty} * {4'd0, unit_price};
  assign sum_wide  = {1'b0, total} + {2'd0, prod};
  assign sum_sat   = sum_wide[13] ? 13'h1FFF : sum_wide[12:0];

  assign disc_hit  = (total >= DISC_THRESH);
  assign disc_calc = disc_hit ? (total >> DISC_SHIFT) : 13'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      total     <= 13'd0;
      ed        <= 1'b0;
      discount  <= 13'd0;
      final_amt <= 13'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            total     <= 13'd0;
            ed        <= 1'b0;
            discount  <= 13'd0;
            final_amt <= 13'd0;
            err       <= 1'b0;
          end
        end
        COLLECT: begin
          // A line offered together with close is still accepted before the bill closes.
          if (accept) begin
            if (item_bad) err   <= 1'b1;
            else          total <= sum_sat;
          end
          if (close) state <= CALC;
        end
        CALC: begin
          ed        <= disc_hit;
          discount  <= disc_calc;
          final_amt <= total - disc_calc;
          state     <= DONE;
        end
        DONE: begin
          if (bill_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BILL_LINE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt <= 5'd0;
    end else if (state == IDLE && start) begin
      line_cnt <= 5'd0;
    end else if (accept && line_cnt != 5'd31) begin
      line_cnt <= line_cnt + 5'd1;
    end
  end
`endif

endmodule

// File: doc/bill_checkout_ctrl.md
BILL_CHECKOUT_CTRL -- requirements
Module: bill_checkout_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have parameters PRICE0..PRICE4, default 10/20/30/40/50, giving the 8-bit unit price of items 0..4.
REQ-003 SHALL have parameter DISC_THRESH, default 500, the 13-bit total at or above which a discount applies.
REQ-004 SHALL have parameter DISC_SHIFT, default 3, with discount = total >> DISC_SHIFT.
REQ-005 SHALL have the ports below (name, direction, width, meaning):
- clk, in, 1, rising-edge clock
- rst_n, in, 1, async active-low reset
- start, in, 1, open a new bill
- item_valid, in, 1, item line offered
- item_ready, out, 1, line can be accepted
- item_id, in, 3, item index 0..4
- qty, in, 4, quantity 0..15
- close, in, 1, end of bill
- bill_valid, out, 1, result held stable
- bill_ack, in, 1, result consumed
- total, out, 13, accumulated amount
- ed, out, 1, eligible for discount
- discount, out, 13, discount amount
- final, out, 13, total minus discount
- err, out, 1, sticky invalid-item flag for the current bill

Function
REQ-006 SHALL implement a four-state FSM: IDLE, COLLECT, CALC, DONE.
REQ-007 In IDLE, start=1 SHALL move to COLLECT next cycle and clear total, ed, discount, final and err; start SHALL be ignored in every other state.
REQ-008 item_ready SHALL be 1 only in COLLECT; a line is accepted on a cycle where item_valid and item_ready are both 1.
REQ-009 An accepted line SHALL update total on the next edge: total <= sat13(total + qty*PRICE[item_id]).
- Product width: 12 bits.
- Saturation: at 8191.
REQ-010 An accepted line with item_id 5..7 SHALL leave total unchanged and set err, which stays set until the next start or reset.
REQ-011 close=1 in COLLECT SHALL move to CALC next cycle.
- If item_valid is also 1 that cycle, the line SHALL be accepted first.
- close outside COLLECT SHALL be ignored.
REQ-012 CALC SHALL last exactly one cycle and register:
- ed = (total >= DISC_THRESH)
- discount = ed ? total >> DISC_SHIFT : 0
- final = total - discount
REQ-013 With close sampled on cycle N, bill_valid SHALL rise on cycle N+2 (DONE).
REQ-014 In DONE, bill_valid SHALL be 1 with total, ed, discount, final and err held constant.
- bill_ack=1 SHALL return the FSM to IDLE next cycle.
- Outputs SHALL keep their values in IDLE until the next start.
REQ-015 A bill closed with zero accepted lines SHALL yield total=0, ed=0, discount=0, final=0.
REQ-016 qty=0 lines SHALL be accepted and SHALL add 0.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- State: IDLE.
- Outputs: item_ready=0, bill_valid=0, total=0, ed=0, discount=0, final=0, err=0.
REQ-018 Reset asserted mid-bill (COLLECT, CALC or DONE) SHALL discard the bill; operation resumes only on a new start.

Configuration
REQ-019 With BILL_LINE_COUNT_EN defined, the block SHALL add output line_cnt[4:0].
- Counts accepted lines, invalid lines included.
- Cleared on start and on reset; saturates at 31.
- Held in DONE.
REQ-020 Without BILL_LINE_COUNT_EN, line_cnt SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-021 Lines (0,10),(1,2),(2,5),(3,10),(4,4), then close -> total=890, ed=1, discount=111, final=779, bill_valid 2 cycles after close.
REQ-022 Lines (0,1),(1,2),(2,1),(3,1),(4,2), then close -> total=220, ed=0, discount=0, final=220.
REQ-023 Four passes of items 0..4 with qty=15 -> total saturates at 8191, discount=1023, final=7168; with the macro, line_cnt=20.
REQ-024 Line (6,5) followed by (2,10), then close -> err=1, total=300, ed=0, final=300; item_valid held while in DONE -> no acceptance.
REQ-025 rst_n pulsed low in COLLECT after one line -> all outputs 0 immediately, state IDLE; a following start with (4,15) and close -> total=750, discount=93, final=657.
REQ-026 close with item_valid on the same cycle for (1,1) after (0,1) -> total=30; start asserted in DONE -> ignored; bill_ack -> IDLE next cycle, outputs retained.
